// File: rtl/cp_inserter.sv
// Cyclic-prefix inserter: buffers one OFDM symbol of N_FFT complex samples, then
// replays its last CP_LEN samples followed by the whole symbol, with valid/ready on both sides.
module cp_inserter #(
  parameter int N_FFT  = 64,
  parameter int CP_LEN = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_real,
  input  logic [DATA_W-1:0] in_imag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_real,
  output logic [DATA_W-1:0] out_imag,
  output logic              out_sos,
  output logic              out_cp,
  output logic              out_eos
);

  localparam int WR_W  = $clog2(N_FFT);
  localparam int CNT_W = $clog2(N_FFT + CP_LEN);

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  localparam logic [WR_W-1:0]  WR_LAST  = WR_W'(N_FFT - 1);
  localparam logic [WR_W-1:0]  CP_START = WR_W'(N_FFT - CP_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_FFT + CP_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_CP   = CNT_W'(CP_LEN);
  // With a one-sample prefix the first emitted sample is the one arriving on the final write.
  localparam bit FWD = (CP_LEN == 1);

  logic [0:0]          state;
  logic [WR_W-1:0]     wr_idx;
  logic [WR_W-1:0]     rd_idx;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] mem [N_FFT];

  logic                in_fire;
  logic                last_in;
  logic                out_fire;
  logic                step_out;
  logic                last_out;
  logic [WR_W-1:0]     next_idx;
  logic [WR_W-1:0]     rd_addr;
  logic [CNT_W-1:0]    cnt_next;
  logic [2*DATA_W-1:0] ld_data;

  assign in_ready = (state == ST_FILL);
  assign in_fire  = in_valid & in_ready;
  assign last_in  = in_fire && (wr_idx == WR_LAST);
  assign out_fire = out_valid & out_ready;
  assign step_out = out_fire && (cnt != CNT_LAST);
  assign last_out = out_fire && (cnt == CNT_LAST);
  assign cnt_next = cnt + 1'b1;
  assign next_idx = (rd_idx == WR_LAST) ? '0 : rd_idx + 1'b1;
  assign rd_addr  = (state == ST_FILL) ? CP_START : next_idx;

  always_comb begin
    ld_data = mem[rd_addr];
    if (FWD && last_in) begin
      ld_data = {in_real, in_imag};
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem[wr_idx] <= {in_real, in_imag};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_FILL;
      wr_idx    <= '0;
      rd_idx    <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_sos   <= 1'b0;
      out_cp    <= 1'b0;
      out_eos   <= 1'b0;
      out_real  <= '0;
      out_imag  <= '0;
    end else begin
      if (in_fire) begin
        wr_idx <= last_in ? '0 : wr_idx + 1'b1;
      end

      if (last_in) begin
        state     <= ST_EMIT;
        cnt       <= '0;
        rd_idx    <= CP_START;
        out_valid <= 1'b1;
        out_sos   <= 1'b1;
        out_cp    <= 1'b1;
        out_eos   <= 1'b0;
        out_real  <= ld_data[2*DATA_W-1:DATA_W];
        out_imag  <= ld_data[DATA_W-1:0];
      end else if (step_out) begin
        cnt       <= cnt_next;
        rd_idx    <= next_idx;
        out_sos   <= 1'b0;
        out_cp    <= (cnt_next < CNT_CP);
        out_eos   <= (cnt_next == CNT_LAST);
        out_real  <= ld_data[2*DATA_W-1:DATA_W];
        out_imag  <= ld_data[DATA_W-1:0];
      end else if (last_out) begin
        state     <= ST_FILL;
        wr_idx    <= '0;
        out_valid <= 1'b0;
        out_sos   <= 1'b0;
        out_cp    <= 1'b0;
        out_eos   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cp_inserter.sv
// Bench for cp_inserter: a 64/16 instance and a CP_LEN=1 instance checked against an
// index-arithmetic model of the emitted prefix-plus-symbol stream.
module tb_cp_inserter;

  localparam int N   = 64;
  localparam int CP  = 16;
  localparam int N1  = 8;
  localparam int CP1 = 1;
  localparam int W   = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [W-1:0] in_real = '0, in_imag = '0, out_real, out_imag;
  logic         out_sos, out_cp, out_eos;

  logic         in1_valid = 1'b0, in1_ready, out1_valid, out1_ready = 1'b0;
  logic [W-1:0] in1_real = '0, in1_imag = '0, out1_real, out1_imag;
  logic         out1_sos, out1_cp, out1_eos;

  cp_inserter #(.N_FFT(N), .CP_LEN(CP), .DATA_W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_real(in_real), .in_imag(in_imag),
    .out_valid(out_valid), .out_ready(out_ready), .out_real(out_real), .out_imag(out_imag),
    .out_sos(out_sos), .out_cp(out_cp), .out_eos(out_eos)
  );

  cp_inserter #(.N_FFT(N1), .CP_LEN(CP1), .DATA_W(W)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in1_valid), .in_ready(in1_ready), .in_real(in1_real), .in_imag(in1_imag),
    .out_valid(out1_valid), .out_ready(out1_ready), .out_real(out1_real), .out_imag(out1_imag),
    .out_sos(out1_sos), .out_cp(out1_cp), .out_eos(out1_eos)
  );

  int tests = 0;
  int fails = 0;
  logic [W-1:0] sym_re [N];
  logic [W-1:0] sym_im [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Expected {real, imag, sos, cp, eos} for output position c of an n-sample symbol with prefix cp.
  function automatic logic [2*W+2:0] model(input int n, input int cp, input int c);
    int idx;
    logic s, p, e;
    idx = (c + n - cp) % n;
    s = (c == 0);
    p = (c < cp);
    e = (c == n + cp - 1);
    return {sym_re[idx], sym_im[idx], s, p, e};
  endfunction

  task automatic randomize_symbol();
    for (int k = 0; k < N; k++) begin
      sym_re[k] = W'($urandom);
      sym_im[k] = W'($urandom);
    end
  endtask

  // Entered and left at a negedge; transfers happen on the posedge in between.
  task automatic push(input int count, input bit gaps);
    for (int k = 0; k < count; k++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        in_real  = W'($urandom);
        @(negedge clk);
      end
      check("in_ready_fill", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_real  = sym_re[k];
      in_imag  = sym_im[k];
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (count == N) begin
      check("first_out_latency", 32'(out_valid), 32'd1);
      check("in_ready_low_emit", 32'(in_ready), 32'd0);
    end
  endtask

  task automatic collect(input int ready_pct);
    int got = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic [2*W+2:0] cur, snap;
    snap = '0;
    while (got < N + CP && cyc < 4000) begin
      cur = {out_real, out_imag, out_sos, out_cp, out_eos};
      check("out_valid_emit", 32'(out_valid), 32'd1);
      check("in_ready_emit", 32'(in_ready), 32'd0);
      if (stalled) check("stall_hold", 32'(cur), 32'(snap));
      out_ready = ($urandom_range(0, 99) < ready_pct);
      in_valid  = $urandom_range(0, 1) == 1;
      in_real   = W'($urandom);
      in_imag   = W'($urandom);
      if (out_valid && out_ready) begin
        check($sformatf("out%0d", got), 32'(cur), 32'(model(N, CP, got)));
        got++;
      end
      stalled = out_valid && !out_ready;
      snap = cur;
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("collect_count", 32'(got), 32'(N + CP));
    if (ready_pct == 100) check("back_to_back_cycles", 32'(cyc), 32'(N + CP));
    check("out_valid_after_eos", 32'(out_valid), 32'd0);
    check("in_ready_after_eos", 32'(in_ready), 32'd1);
    $display("[TB] symbol collected: %0d outputs in %0d cycles", got, cyc);
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_data", 32'({out_real, out_imag, out_sos, out_cp, out_eos}), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Abort a partial symbol with reset, then a fresh symbol must start at index 0
    randomize_symbol();
    push(10, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    randomize_symbol();
    push(N, 1'b0);
    collect(100);

    // Ramp symbol, no backpressure
    for (int k = 0; k < N; k++) begin
      sym_re[k] = W'(k - 32);
      sym_im[k] = W'(32 - k);
    end
    push(N, 1'b0);
    collect(100);

    // Random data with 50% backpressure
    randomize_symbol();
    push(N, 1'b0);
    collect(50);

    // Two consecutive symbols with input gaps
    for (int s = 0; s < 2; s++) begin
      randomize_symbol();
      push(N, 1'b1);
      collect(100);
    end

    // CP_LEN=1 instance: last input forwarded as the first output
    randomize_symbol();
    sym_re[N1-1] = 8'h7F;
    for (int k = 0; k < N1; k++) begin
      in1_valid = 1'b1;
      in1_real  = sym_re[k];
      in1_imag  = sym_im[k];
      @(negedge clk);
    end
    in1_valid  = 1'b0;
    out1_ready = 1'b1;
    check("cp1_first_real", 32'(out1_real), 32'h7F);
    for (int c = 0; c < N1 + CP1; c++) begin
      check($sformatf("cp1_out%0d", c),
            32'({out1_valid, out1_real, out1_imag, out1_sos, out1_cp, out1_eos}),
            32'({1'b1, model(N1, CP1, c)}));
      @(negedge clk);
    end
    out1_ready = 1'b0;
    check("cp1_out_valid_after_eos", 32'(out1_valid), 32'd0);
    check("cp1_in_ready_after_eos", 32'(in1_ready), 32'd1);
    $display("[TB] cp1 symbol collected: %0d outputs", N1 + CP1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cp_inserter.md
Name: cp_inserter

Overview:
- Transmit-side counterpart of the receive CP correlator (sliding-window r_k·conj(r_k-N) sum over the CP length).
- Collects one OFDM symbol of N_FFT complex time-domain samples (r_t, Q1.6), then emits the symbol prefixed by a cyclic prefix: its last CP_LEN samples, then all N_FFT samples in order.
- Produces the waveform the correlator is built to detect; sits between the IFFT output and the DAC/channel model.
- Single symbol buffer; input and output phases alternate and do not overlap.

Parameters:
- N_FFT, 64, samples per symbol (≥2, power of two not required).
- CP_LEN, 16, cyclic-prefix length; legal range 1..N_FFT-1; matches the correlator window L.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-low.
- in_valid  input  1  input sample valid.
- in_ready  output  1  block can accept a sample.
- in_real  input  r_t  input sample, real part.
- in_imag  input  r_t  input sample, imaginary part.
- out_valid  output  1  output sample valid.
- out_ready  input  1  downstream accepts sample.
- out_real  output  r_t  output sample, real part.
- out_imag  output  r_t  output sample, imaginary part.
- out_sos  output  1  first sample of emitted symbol (first CP sample).
- out_cp  output  1  current output sample belongs to the CP.
- out_eos  output  1  last sample of emitted symbol.

Behaviour:
- Reset (rst=0, async): state=FILL, wr_idx=0, cnt=0, out_valid=0, out_real=out_imag=0, out_sos=out_cp=out_eos=0. Buffer contents need not be cleared.
- States: FILL, EMIT.
- FILL:
  - in_ready=1 (combinational from state); out_valid=0.
  - On in_valid&in_ready: buf[wr_idx] <= {in_real,in_imag}; wr_idx++.
  - Gaps in in_valid hold wr_idx.
  - On the transfer with wr_idx==N_FFT-1: next state EMIT, cnt<=0, out_valid<=1. Output regs load sample index N_FFT-CP_LEN with out_sos=1, out_cp=1, out_eos=0.
  - When CP_LEN==1 that index is the sample being written this cycle; it is forwarded from in_real/in_imag, not read from buf.
  - Latency: first output sample is valid the cycle after the last input transfer.
- EMIT:
  - in_ready=0; in_valid is ignored.
  - Emission order: cnt runs 0..N_FFT+CP_LEN-1; sample index = (cnt + N_FFT - CP_LEN) mod N_FFT.
  - out_cp=1 iff cnt<CP_LEN; out_sos=1 iff cnt==0; out_eos=1 iff cnt==N_FFT+CP_LEN-1.
  - All out_* are registered. While out_valid&!out_ready, every out_* holds stable (AXI-style: valid never drops without a transfer).
  - On out_valid&out_ready with cnt<last: cnt++, and output regs load the next index and flags in the same edge. Back-to-back transfers run at 1 sample/cycle.
  - On out_valid&out_ready with cnt==last: out_valid<=0, flags<=0, state FILL, wr_idx<=0. in_ready rises the following cycle. Data regs may hold the last value.
- Period: N_FFT input transfers + N_FFT+CP_LEN output transfers per symbol, no overlap.
- Arithmetic: pure data movement; samples pass bit-exact, with no scaling or saturation.
- Counter widths: wr_idx is $clog2(N_FFT) bits; cnt is $clog2(N_FFT+CP_LEN) bits.
- Reset mid-operation: any state aborts immediately to the reset values; a partial symbol is discarded, and the next accepted sample is index 0.
- Simultaneous events: in EMIT an in_valid is simply not accepted (in_ready=0). There is no case where input and output transfer in the same cycle.

Test Plan:
- Reset: hold rst=0 mid-FILL after 10 samples, release -> out_valid=0, in_ready=1. The next 64 samples form a fresh symbol: first output is sample 48 of the new data.
- Basic, N=64/CP=16, out_ready=1: input real=k-32, imag=-(k-32) for k=0..63 -> 80 outputs, each one cycle apart.
  - Outputs 0..15 equal samples 48..63 with out_cp=1; output 0 has out_sos=1.
  - Outputs 16..79 equal samples 0..63 with out_cp=0; output 79 has out_eos=1.
  - First out_valid appears 1 cycle after input k=63.
- Backpressure: random out_ready at 50% -> same 80-sample sequence. Data and flags are stable during every stall; no sample is lost or duplicated.
- Input gaps: in_valid toggling 1/0 -> buffer order is preserved; in_ready=0 throughout EMIT. Two consecutive symbols are emitted correctly with in_ready re-rising after the eos transfer.
- CP_LEN=1 build: last input sample value 0x7F -> first output 0x7F with out_sos=1 and out_cp=1 (forwarding path), followed by samples 0..N-1.
- Loopback: feed two symbols of random ±0.5 QPSK data into the correlator. The correlator's gamma_out_real peaks (16×0.5 = 8.0 in Q6.8 = 0x800) at the end of each CP window.
